// File: rtl/psram_qpi_responder.sv
// psram_qpi_responder
//   Behavioural-but-synthesizable PSRAM target for SPI/QPI controllers.
//   The serial clock is oversampled by clk_i. Data on din is captured on sck
//   rising edges, and read data is launched on dout at sck falling edges.
//   Power-up is in SPI mode. SPI command 0x35 enters QPI mode. QPI commands
//   0xEB (read with WAIT_CYCLES dummy clocks) and 0x38 (write) take a 24-bit
//   address. Only the low ADDR_W address bits select a byte, and addresses
//   wrap within the backing array.
//   Optional feature macro: PSRAM_RESP_QPI_EXIT_EN -- QPI command 0xF5 leaves
//   QPI mode when ce_n rises. Without it, 0xF5 is an unknown command.
//   Ports:
//     clk_i  : system clock, all state changes on its rising edge
//     rst_i  : asynchronous active-high reset (memory contents kept)
//     sck    : serial clock from the controller
//     ce_n   : active-low chip enable
//     din    : controller data (din[0] only in SPI mode)
//     dout   : read data nibble
//     douten : output enable, 4'hF while driving read data, else 4'h0
//   ADDR_W must be at least 5 and at most 24.
module psram_qpi_responder #(
  parameter int ADDR_W      = 12,
  parameter int WAIT_CYCLES = 6
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       sck,
  input  logic       ce_n,
  input  logic [3:0] din,
  output logic [3:0] dout,
  output logic [3:0] douten
);

  typedef enum logic [2:0] {
    IDLE, SPI_CMD, QPI_CMD, ADDR, DUMMY, RDATA, WDATA, IGNORE
  } state_t;

  localparam logic [7:0] CMD_QPI_ENTER = 8'h35;
  localparam logic [7:0] CMD_READ      = 8'hEB;
  localparam logic [7:0] CMD_WRITE     = 8'h38;
`ifdef PSRAM_RESP_QPI_EXIT_EN
  localparam logic [7:0] CMD_QPI_EXIT  = 8'hF5;
`endif
  localparam logic [7:0] DUMMY_LAST    = 8'(WAIT_CYCLES - 1);

  state_t            r_state, w_next;
  logic              r_sck_q;
  logic              w_rise, w_fall;
  logic              r_qpi_mode;
  logic              r_qpi_set;      // mode change held until ce_n rises
  logic              r_qpi_clr;
  logic [7:0]        r_cmd;
  logic [7:0]        r_cnt;          // bit / nibble / dummy counter
  logic              r_nib;          // 0: high nibble next, 1: low nibble next
  logic [3:0]        r_whi;          // pending high nibble of a write byte
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_mem [0:(1<<ADDR_W)-1];
  logic [7:0]        w_cmd_spi_next, w_cmd_qpi_next, w_rd_byte;
  logic              w_mem_we;

  assign w_rise         = sck & ~r_sck_q;
  assign w_fall         = ~sck & r_sck_q;
  assign w_cmd_spi_next = {r_cmd[6:0], din[0]};
  assign w_cmd_qpi_next = {r_cmd[3:0], din};
  assign w_rd_byte      = r_mem[r_addr];
  assign w_mem_we       = ~ce_n && (r_state == WDATA) && w_rise && r_nib;

  always_comb begin
    w_next = r_state;
    if (ce_n) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE:    w_next = r_qpi_mode ? QPI_CMD : SPI_CMD;
        // Every SPI command ends in IGNORE; 0x35 only arms the mode switch.
        SPI_CMD: if (w_rise && r_cnt == 8'd7) w_next = IGNORE;
        QPI_CMD: if (w_rise && r_cnt == 8'd1)
                   w_next = (w_cmd_qpi_next == CMD_READ || w_cmd_qpi_next == CMD_WRITE)
                            ? ADDR : IGNORE;
        ADDR:    if (w_rise && r_cnt == 8'd5) begin
                   if (r_cmd == CMD_READ) w_next = (WAIT_CYCLES == 0) ? RDATA : DUMMY;
                   else                   w_next = WDATA;
                 end
        DUMMY:   if (w_rise && r_cnt == DUMMY_LAST) w_next = RDATA;
        default: w_next = r_state;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= IDLE;
      r_sck_q    <= 1'b0;
      r_qpi_mode <= 1'b0;
      r_qpi_set  <= 1'b0;
      r_qpi_clr  <= 1'b0;
      r_cmd      <= 8'h00;
      r_cnt      <= 8'h00;
      r_nib      <= 1'b0;
      r_whi      <= 4'h0;
      r_addr     <= '0;
      dout       <= 4'h0;
      douten     <= 4'h0;
    end else begin
      r_sck_q <= sck;
      r_state <= w_next;
      if (ce_n) begin
        douten <= 4'h0;
        r_cnt  <= 8'h00;
        r_nib  <= 1'b0;
        if (r_qpi_set) r_qpi_mode <= 1'b1;
        if (r_qpi_clr) r_qpi_mode <= 1'b0;
        r_qpi_set <= 1'b0;
        r_qpi_clr <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            r_cnt <= 8'h00;
            r_nib <= 1'b0;
          end
          SPI_CMD: if (w_rise) begin
            r_cmd <= w_cmd_spi_next;
            r_cnt <= r_cnt + 8'd1;
            if (r_cnt == 8'd7) begin
              r_cnt <= 8'h00;
              if (w_cmd_spi_next == CMD_QPI_ENTER) r_qpi_set <= 1'b1;
            end
          end
          QPI_CMD: if (w_rise) begin
            r_cmd <= w_cmd_qpi_next;
            r_cnt <= r_cnt + 8'd1;
            if (r_cnt == 8'd1) begin
              r_cnt <= 8'h00;
`ifdef PSRAM_RESP_QPI_EXIT_EN
              if (w_cmd_qpi_next == CMD_QPI_EXIT) r_qpi_clr <= 1'b1;
`endif
            end
          end
          ADDR: if (w_rise) begin
            // Shifting past ADDR_W bits drops the unused upper address bits.
            r_addr <= {r_addr[ADDR_W-5:0], din};
            r_cnt  <= (r_cnt == 8'd5) ? 8'h00 : r_cnt + 8'd1;
          end
          DUMMY: if (w_rise) begin
            r_cnt <= (r_cnt == DUMMY_LAST) ? 8'h00 : r_cnt + 8'd1;
          end
          RDATA: if (w_fall) begin
            douten <= 4'hF;
            if (!r_nib) begin
              dout  <= w_rd_byte[7:4];
              r_nib <= 1'b1;
            end else begin
              dout   <= w_rd_byte[3:0];
              r_addr <= r_addr + 1'b1;
              r_nib  <= 1'b0;
            end
          end
          WDATA: if (w_rise) begin
            if (!r_nib) begin
              r_whi <= din;
              r_nib <= 1'b1;
            end else begin
              r_addr <= r_addr + 1'b1;
              r_nib  <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Backing store: not reset, so contents survive rst_i.
  always_ff @(posedge clk_i) begin
    if (w_mem_we) r_mem[r_addr] <= {r_whi, din};
  end

endmodule

// File: tb/tb_psram_qpi_responder.sv
module tb_psram_qpi_responder;

  localparam int WAIT = 6;
  localparam int H    = 2;   // clk_i cycles per sck half period

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       sck;
  logic       ce_n;
  logic [3:0] din;
  logic [3:0] dout;
  logic [3:0] douten;

  psram_qpi_responder #(.ADDR_W(12), .WAIT_CYCLES(WAIT)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .sck(sck), .ce_n(ce_n),
    .din(din), .dout(dout), .douten(douten)
  );

  always #5 clk_i = ~clk_i;

  int         vectors = 0;
  int         miscompares = 0;
  logic [3:0] exp_q[$];
  logic [7:0] wbuf[$];
  logic [7:0] mem_m [4096];
  bit         qpi_m;
  bit         expect_drive = 1'b0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: the controller samples read data on every sck rise.
  always @(posedge sck) begin
    if (!ce_n) begin
      check("douten_on_rise", {4'h0, douten}, expect_drive ? 8'h0F : 8'h00);
      if (expect_drive) begin
        if (exp_q.size() == 0) begin
          check("unexpected_read_nibble", {4'h0, dout}, 8'hEE);
        end else begin
          logic [3:0] e;
          e = exp_q.pop_front();
          check("read_nibble", {4'h0, dout}, {4'h0, e});
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic sck_cycle(input logic [3:0] d);
    din = d;
    tick(H);
    sck = 1'b1;
    tick(H);
    sck = 1'b0;
  endtask

  task automatic cs_begin();
    ce_n = 1'b0;
    tick(2);
  endtask

  task automatic cs_end();
    tick(2);
    expect_drive = 1'b0;
    ce_n = 1'b1;
    tick(3);
  endtask

  task automatic spi_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) sck_cycle({3'b000, b[i]});
  endtask

  task automatic qpi_byte(input logic [7:0] b);
    sck_cycle(b[7:4]);
    sck_cycle(b[3:0]);
  endtask

  task automatic qpi_addr(input logic [23:0] a);
    for (int i = 5; i >= 0; i--) sck_cycle(a[i*4 +: 4]);
  endtask

  // Writes wbuf starting at a; the model stores bytes modulo 4096.
  task automatic qpi_write(input logic [11:0] a);
    cs_begin();
    qpi_byte(8'h38);
    qpi_addr({12'hABC, a});   // upper address bits must be ignored
    foreach (wbuf[i]) begin
      qpi_byte(wbuf[i]);
      mem_m[a + 12'(i)] = wbuf[i];
    end
    cs_end();
  endtask

  task automatic qpi_read(input logic [11:0] a, input int n);
    logic [7:0] b;
    cs_begin();
    qpi_byte(8'hEB);
    qpi_addr({12'h000, a});
    repeat (WAIT) sck_cycle(4'($urandom));
    for (int i = 0; i < n; i++) begin
      b = mem_m[a + 12'(i)];
      exp_q.push_back(b[7:4]);
      exp_q.push_back(b[3:0]);
    end
    expect_drive = 1'b1;
    repeat (2 * n) sck_cycle(4'h0);
    cs_end();
    check("douten_after_ce_high", {4'h0, douten}, 8'h00);
  endtask

  task automatic check_mode(input string name);
    check(name, {7'h0, dut.r_qpi_mode}, {7'h0, qpi_m});
  endtask

  initial begin
    logic [7:0] b;
    int len, off;
    rst_i = 1'b1; ce_n = 1'b1; sck = 1'b0; din = 4'h0;
    tick(3);
    check("reset_douten", {4'h0, douten}, 8'h00);
    check("reset_dout", {4'h0, dout}, 8'h00);
    qpi_m = 1'b0;
    check_mode("reset_qpi_mode");
    rst_i = 1'b0;
    tick(2);

    // SPI command other than 0x35 leaves the part in SPI mode, never driving.
    cs_begin(); spi_byte(8'h9F); repeat (4) sck_cycle(4'hF); cs_end();
    check_mode("spi_9f_mode");

    // Enter QPI mode.
    cs_begin(); spi_byte(8'h35); cs_end();
    qpi_m = 1'b1;
    check_mode("spi_35_mode");

    // Prefill a window 0xFF0..0x03F (crosses the wrap point).
    wbuf.delete();
    for (int i = 0; i < 80; i++) wbuf.push_back(8'($urandom));
    qpi_write(12'hFF0);

    // Write then read.
    wbuf.delete(); wbuf.push_back(8'hA5); wbuf.push_back(8'h3C);
    qpi_write(12'h010);
    qpi_read(12'h010, 2);

    // Wrap-around.
    wbuf.delete(); wbuf.push_back(8'h11); wbuf.push_back(8'h22);
    qpi_write(12'hFFF);
    qpi_read(12'hFFF, 2);

    // Abort after 3 data nibbles: only the first byte lands.
    cs_begin();
    qpi_byte(8'h38); qpi_addr(24'h000020);
    qpi_byte(8'h77); sck_cycle(4'h8);
    mem_m[12'h020] = 8'h77;
    cs_end();
    check("abort_douten", {4'h0, douten}, 8'h00);
    qpi_read(12'h020, 2);

    // Unknown QPI command: ignored, mode unchanged.
    cs_begin(); qpi_byte(8'h9F); repeat (6) sck_cycle(4'h5); cs_end();
    check_mode("qpi_unknown_mode");

    // Randomized reads and writes within the prefilled window.
    for (int t = 0; t < 24; t++) begin
      len = $urandom_range(1, 6);
      off = $urandom_range(0, 80 - len);
      if ($urandom_range(0, 1) == 0) begin
        wbuf.delete();
        for (int i = 0; i < len; i++) wbuf.push_back(8'($urandom));
        qpi_write(12'hFF0 + 12'(off));
      end else begin
        qpi_read(12'hFF0 + 12'(off), len);
      end
    end

    // QPI exit command.
    cs_begin(); qpi_byte(8'hF5); cs_end();
`ifdef PSRAM_RESP_QPI_EXIT_EN
    qpi_m = 1'b0;
`endif
    check_mode("f5_mode");
    if (!qpi_m) begin
      cs_begin(); spi_byte(8'h35); cs_end();
      qpi_m = 1'b1;
      check_mode("reenter_mode");
    end

    // Reset during RDATA.
    cs_begin();
    qpi_byte(8'hEB); qpi_addr(24'h000010);
    repeat (WAIT) sck_cycle(4'h0);
    b = mem_m[12'h010];
    exp_q.push_back(b[7:4]);
    expect_drive = 1'b1;
    sck_cycle(4'h0);
    expect_drive = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    qpi_m = 1'b0;
    check("rst_rdata_douten", {4'h0, douten}, 8'h00);
    check_mode("rst_rdata_mode");
    ce_n = 1'b1;
    tick(2);
    rst_i = 1'b0;
    tick(2);

    // After reset the part is in SPI mode: 0xEB is just an ignored SPI byte.
    cs_begin(); spi_byte(8'hEB); repeat (8) sck_cycle(4'h0); cs_end();
    check_mode("post_reset_spi_mode");

    // Memory survives reset.
    cs_begin(); spi_byte(8'h35); cs_end();
    qpi_m = 1'b1;
    check_mode("post_reset_reenter");
    qpi_read(12'hFFE, 4);

    check("scoreboard_empty", 8'(exp_q.size()), 8'h00);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
